// File: rtl/hr_bridge_xfer_fifo.sv
// hr_bridge_xfer_fifo
//   Transfer FIFO on the far end of an HRbridge FIFO port. The bridge pushes
//   flits with enQ_i/data_i. The head flit is presented back on data_o
//   (first-word-fall-through). The bridge pops it with deQ_i. bfull_o is an
//   almost-full indication that lets the bridge throttle despite its one-cycle
//   bfull reaction latency.
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   enQ_i    push data_i this cycle
//   data_i   flit to push (contents opaque, all-zero flits are stored as-is)
//   deQ_i    pop the head flit this cycle
//   data_o   head flit, all-zero when the FIFO is empty
//   bfull_o  count >= DEPTH-AFULL_SLACK
//   empty_o  count == 0
//   count_o  occupancy 0..DEPTH
//   ovf_o    sticky, set when a push was dropped because the FIFO was full
module hr_bridge_xfer_fifo #(
    parameter int unsigned WIDTH       = 144,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_SLACK = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enQ_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     deQ_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     bfull_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(DEPTH - AFULL_SLACK);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             ovf;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is accepted only when a pop frees the slot in
    // the same cycle. A pop on empty is ignored, so there is no bypass path.
    always_comb begin
        push_ok = enQ_i & ((count < DEPTH_C) | (deQ_i & (count == DEPTH_C)));
        pop_ok  = deQ_i & (count != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + PW'(push_ok) - PW'(pop_ok);
            if (enQ_i && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; entries are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_comb begin
        data_o  = (count != '0) ? mem[rd_ptr[AW-1:0]] : '0;
        bfull_o = (count >= AFULL_C);
        empty_o = (count == '0);
        count_o = count;
        ovf_o   = ovf;
    end

endmodule

// File: tb/tb_hr_bridge_xfer_fifo.sv
module tb_hr_bridge_xfer_fifo;

    localparam int unsigned WIDTH = 144;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SLACK = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enq;
    logic [WIDTH-1:0] din;
    logic             deq;
    logic [WIDTH-1:0] dout;
    logic             bfull;
    logic             empty;
    logic [2:0]       cnt;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hr_bridge_xfer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_SLACK(SLACK)) dut (
        .clk     (clk),
        .rst     (rst),
        .enQ_i   (enq),
        .data_i  (din),
        .deQ_i   (deq),
        .data_o  (dout),
        .bfull_o (bfull),
        .empty_o (empty),
        .count_o (cnt),
        .ovf_o   (ovf)
    );

    typedef struct {
        logic             rst;
        logic             enq;
        logic             deq;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        int unsigned      cnt;
        logic             empty;
        logic             bfull;
        logic             ovf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [WIDTH-1:0] P  = 144'h0123456789abcdef0123456789abcdef1851;
    localparam logic [WIDTH-1:0] FA = {36{4'hA}};
    localparam logic [WIDTH-1:0] FB = {36{4'hB}};
    localparam logic [WIDTH-1:0] FC = {36{4'hC}};
    localparam logic [WIDTH-1:0] FD = {36{4'hD}};
    localparam logic [WIDTH-1:0] FE = {36{4'hE}};
    localparam logic [WIDTH-1:0] FF = {36{4'hF}};
    localparam logic [WIDTH-1:0] FG = {18{8'h96}};
    localparam logic [WIDTH-1:0] FH = {18{8'h3C}};
    localparam logic [WIDTH-1:0] Z  = '0;

    task automatic add(input logic r, input logic e, input logic d, input logic [WIDTH-1:0] di,
                       input logic [WIDTH-1:0] dx, input int unsigned c, input logic em,
                       input logic bf, input logic ov);
        vec_t v;
        v.rst = r; v.enq = e; v.deq = d; v.din = di; v.dout = dx;
        v.cnt = c; v.empty = em; v.bfull = bf; v.ovf = ov;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] x_d, input int unsigned x_c,
                             input logic x_e, input logic x_b, input logic x_o);
        check({tag, ".data"},  dout, x_d);
        check({tag, ".count"}, WIDTH'(cnt), WIDTH'(x_c));
        check({tag, ".empty"}, WIDTH'(empty), WIDTH'(x_e));
        check({tag, ".bfull"}, WIDTH'(bfull), WIDTH'(x_b));
        check({tag, ".ovf"},   WIDTH'(ovf), WIDTH'(x_o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic d, input logic [WIDTH-1:0] di);
        enq = e; deq = d; din = di;
    endtask

    // reference model state for random phase
    logic [WIDTH-1:0] q[$];
    logic             m_ovf;

    initial begin
        rst = 1'b1;
        drive(0, 0, Z);
        step();
        step();
        check_all("reset", Z, 0, 1, 0, 0);
        rst = 1'b0;

        // ---------------- table-driven sequences ----------------
        //  rst enq deq din  dout cnt empty bfull ovf
        add(0, 1, 0, P,  P,  1, 0, 0, 0);   // push on empty, visible after one edge
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);   // pop -> empty, data 0
        add(0, 1, 0, FA, FA, 1, 0, 0, 0);
        add(0, 1, 0, FB, FA, 2, 0, 0, 0);
        add(0, 1, 0, FC, FA, 3, 0, 1, 0);   // almost-full at 3
        add(0, 1, 0, FD, FA, 4, 0, 1, 0);
        add(0, 1, 0, FE, FA, 4, 0, 1, 1);   // dropped, ovf sticky
        add(0, 0, 1, Z,  FB, 3, 0, 1, 1);
        add(0, 0, 1, Z,  FC, 2, 0, 0, 1);
        add(0, 0, 1, Z,  FD, 1, 0, 0, 1);
        add(0, 0, 1, Z,  Z,  0, 1, 0, 1);
        add(1, 0, 0, Z,  Z,  0, 1, 0, 0);   // reset clears ovf
        add(0, 1, 0, FA, FA, 1, 0, 0, 0);
        add(0, 1, 0, FB, FA, 2, 0, 0, 0);
        add(0, 1, 0, FC, FA, 3, 0, 1, 0);
        add(0, 1, 0, FD, FA, 4, 0, 1, 0);
        add(0, 1, 1, FF, FB, 4, 0, 1, 0);   // full push+pop
        add(0, 0, 1, Z,  FC, 3, 0, 1, 0);
        add(0, 0, 1, Z,  FD, 2, 0, 0, 0);
        add(0, 0, 1, Z,  FF, 1, 0, 0, 0);
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);
        add(0, 1, 1, FG, FG, 1, 0, 0, 0);   // empty push+pop: push only
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);   // pop on empty x3
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);
        add(0, 1, 0, Z,  Z,  1, 0, 0, 0);   // zero flit stored as-is
        add(0, 1, 0, FH, Z,  2, 0, 0, 0);
        add(0, 0, 1, Z,  FH, 1, 0, 0, 0);
        add(0, 0, 1, Z,  Z,  0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].enq, vecs[i].deq, vecs[i].din);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt,
                      vecs[i].empty, vecs[i].bfull, vecs[i].ovf);
        end
        rst = 1'b0;
        drive(0, 0, Z);
        step();

        // ---------------- async reset mid-run ----------------
        drive(1, 0, FA); step();
        drive(1, 0, FB); step();
        drive(1, 0, FC); step();
        drive(1, 0, FD); step();
        drive(1, 0, FE); step();            // dropped -> ovf=1
        drive(0, 1, Z);  step();            // 3 flits held
        drive(0, 0, Z);
        check_all("pre_rst", FB, 3, 0, 1, 1);
        #3 rst = 1'b1;
        #1 check_all("async_rst", Z, 0, 1, 0, 0);
        step();
        rst = 1'b0;
        drive(1, 0, FG); step();
        drive(0, 0, Z);
        check_all("post_rst_push", FG, 1, 0, 0, 0);
        drive(0, 1, Z); step();
        drive(0, 0, Z);

        // ---------------- pointer wrap, back-to-back ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1, (i != 0), WIDTH'(32'h1000 + i));
            step();
            check_all($sformatf("wrap%0d", i), WIDTH'(32'h1000 + i), 1, 0, 0, 0);
        end
        drive(0, 1, Z); step();
        drive(0, 0, Z);
        check_all("wrap_end", Z, 0, 1, 0, 0);

        // ---------------- randomized vs queue model ----------------
        rst = 1'b1; step(); rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic             e, d;
            logic [WIDTH-1:0] v;
            logic             did_pop;
            e = ($urandom_range(0, 99) < 60);
            d = ($urandom_range(0, 99) < 45);
            v = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            if ($urandom_range(0, 15) == 0) v = '0;
            drive(e, d, v);
            step();
            did_pop = 1'b0;
            if (d && q.size() > 0) begin
                void'(q.pop_front());
                did_pop = 1'b1;
            end
            if (e) begin
                if (q.size() < DEPTH) q.push_back(v);
                else m_ovf = 1'b1;
            end
            check_all($sformatf("rnd%0d", c), (q.size() > 0) ? q[0] : Z, q.size(),
                      q.size() == 0, q.size() >= DEPTH - SLACK, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
